// File: rtl/i2s_master_tx_if.sv
// i2s_master_tx_if: sample-pair stream between the audio processing chain
// and the I2S master transmitter.
//
// Signals:
//   ldata  left-channel sample, two's complement, passed through untouched
//   rdata  right-channel sample
//   s_vld  producer has a valid ldata/rdata pair
//   s_rdy  transmitter can accept a pair this cycle
//
// Modports:
//   master  producer side (drives data and valid, observes ready)
//   slave   transmitter side (observes data and valid, drives ready)
interface i2s_master_tx_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] ldata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  s_vld;
  logic                  s_rdy;

  modport master (output ldata, output rdata, output s_vld, input s_rdy);
  modport slave  (input ldata, input rdata, input s_vld, output s_rdy);
endinterface

// File: rtl/i2s_master_tx.sv
// i2s_master_tx: I2S (Philips format) master transmitter. Derives SCLK and
// LRCK from the MCLK-domain clock and serialises one stereo sample pair per
// frame to the DAC SDIN pin. A one-deep holding register decouples the
// producer from the frame timing.
//
// Ports:
//   clk          MCLK-domain clock, sole clock
//   rst_n        asynchronous active-low reset
//   en           1 = run the bus; 0 = finish the current frame, then stop
//   s_if         slave side of the sample-pair stream (ldata/rdata/s_vld/s_rdy)
//   sck          I2S bit clock
//   ws           I2S word select, 0 = left, 1 = right
//   sda          I2S serial data, MSB first
//   frame_start  1-cycle pulse in the first cycle of every frame
//   underrun     1-cycle pulse alongside frame_start when no pair was held
//   busy         transmitter is running a frame
module i2s_master_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int SLOT_WIDTH = 32,
  parameter int BCLK_DIV   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  i2s_master_tx_if.slave    s_if,
  output logic              sck,
  output logic              ws,
  output logic              sda,
  output logic              frame_start,
  output logic              underrun,
  output logic              busy
);

  localparam int FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int BW         = $clog2(FRAME_BITS);
  localparam int DW         = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam int IW         = $clog2(DATA_WIDTH);

  typedef enum logic {IDLE, RUN} state_e;

  state_e                state_q, state_d;
  logic [DW-1:0]         div_q, div_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic                  hold_full_q, hold_full_d;
  logic [DATA_WIDTH-1:0] hold_l_q, hold_l_d;
  logic [DATA_WIDTH-1:0] hold_r_q, hold_r_d;
  logic [DATA_WIDTH-1:0] left_q, left_d;
  logic [DATA_WIDTH-1:0] right_q, right_d;
  logic                  sck_q, sck_d;
  logic                  ws_q, ws_d;
  logic                  sda_q, sda_d;
  logic                  frame_start_q, frame_start_d;
  logic                  underrun_q, underrun_d;
  logic                  load;
  logic                  accept;
  int                    b;

  // Next-state logic. The pin outputs are computed from the *next* counter
  // and shifter values so that the registered pins line up exactly with the
  // counters: sck falls, and ws/sda change, on the cycle div_cnt wraps to 0.
  always_comb begin
    state_d       = state_q;
    div_d         = div_q;
    bit_d         = bit_q;
    hold_full_d   = hold_full_q;
    hold_l_d      = hold_l_q;
    hold_r_d      = hold_r_q;
    left_d        = left_q;
    right_d       = right_q;
    load          = 1'b0;
    sck_d         = 1'b0;
    ws_d          = 1'b0;
    sda_d         = 1'b0;
    b             = 0;

    case (state_q)
      IDLE: begin
        div_d = '0;
        bit_d = '0;
        if (en) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (div_q == DW'(BCLK_DIV - 1)) begin
          div_d = '0;
          if (bit_q == BW'(FRAME_BITS - 1)) begin
            bit_d = '0;
            // en only matters at the frame boundary, so a frame is never cut short
            if (en) load = 1'b1;
            else    state_d = IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A pair may be accepted on the same cycle the holding register is
    // emptied into the shifters, so a steady producer never loses a slot.
    accept = s_if.s_vld & (~hold_full_q | load);

    if (load) begin
      hold_full_d = 1'b0;
      left_d      = hold_full_q ? hold_l_q : '0;
      right_d     = hold_full_q ? hold_r_q : '0;
    end
    if (accept) begin
      hold_full_d = 1'b1;
      hold_l_d    = s_if.ldata;
      hold_r_d    = s_if.rdata;
    end

    frame_start_d = load;
    underrun_d    = load & ~hold_full_q;

    if (state_d == RUN) begin
      b     = int'(bit_d);
      sck_d = (int'(div_d) >= BCLK_DIV / 2);
      // ws leads the MSB of each slot by one bit clock
      ws_d  = (b >= SLOT_WIDTH - 1) && (b <= FRAME_BITS - 2);
      if (b < DATA_WIDTH)
        sda_d = left_d[IW'(DATA_WIDTH - 1 - b)];
      else if ((b >= SLOT_WIDTH) && (b < SLOT_WIDTH + DATA_WIDTH))
        sda_d = right_d[IW'(DATA_WIDTH - 1 - (b - SLOT_WIDTH))];
    end
  end

  assign s_if.s_rdy = ~hold_full_q | load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      div_q         <= '0;
      bit_q         <= '0;
      hold_full_q   <= 1'b0;
      hold_l_q      <= '0;
      hold_r_q      <= '0;
      left_q        <= '0;
      right_q       <= '0;
      sck_q         <= 1'b0;
      ws_q          <= 1'b0;
      sda_q         <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      bit_q         <= bit_d;
      hold_full_q   <= hold_full_d;
      hold_l_q      <= hold_l_d;
      hold_r_q      <= hold_r_d;
      left_q        <= left_d;
      right_q       <= right_d;
      sck_q         <= sck_d;
      ws_q          <= ws_d;
      sda_q         <= sda_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  assign sck         = sck_q;
  assign ws          = ws_q;
  assign sda         = sda_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;
  assign busy        = (state_q != IDLE);

endmodule
